// File: rtl/bot_cmd_pacer.sv
// Paces LFSR-bot moves against keyboard moves into a small FWFT queue
// and holds the engine link off for a fixed time after each hard drop.
module bot_cmd_pacer #(
   parameter int unsigned PERIOD      = 25_000_000,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned LOCK_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bot_en,
   input  logic [7:0]               bot_cmd,
   input  logic                     key_valid,
   input  logic [2:0]               key_cmd,
   input  logic                     clr_ovf,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_cmd,
   output logic                     out_src,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(PERIOD);
   localparam int KW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   localparam logic [2:0]    HARD_DROP = 3'b110;
   localparam logic [TW-1:0] TICK_LAST = TW'(PERIOD - 1);
   localparam logic [KW-1:0] LOCK_LOAD = KW'(LOCK_CYCLES - 1);
   localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);

   typedef enum logic {
      RUN,
      LOCK
   } state_t;

   function automatic logic is_move(input logic [2:0] c);
      return (c != 3'b000) && (c != 3'b111);
   endfunction

   logic [TW-1:0] tick_cnt;
   logic          bot_tick;

   logic          key_ok;
   logic          bot_ok;
   logic          cand;
   logic [3:0]    cand_ent;

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;
   logic [3:0]    head;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          drop;

   state_t        state;
   state_t        state_nx;
   logic [KW-1:0] lock_cnt;
   logic [KW-1:0] lock_nx;

   assign bot_tick = bot_en && (tick_cnt == TICK_LAST);

   // Any key strobe restarts the bot period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (!bot_en || key_valid || bot_tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign key_ok = key_valid && is_move(key_cmd);
   assign bot_ok = bot_tick && !key_valid &&
                   (bot_cmd[7:3] == 5'd0) && is_move(bot_cmd[2:0]);

   always_comb begin
      cand     = 1'b0;
      cand_ent = '0;
      if (key_ok) begin
         cand     = 1'b1;
         cand_ent = {1'b1, key_cmd};
      end else if (bot_ok) begin
         cand     = 1'b1;
         cand_ent = {1'b0, bot_cmd[2:0]};
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (level == FULL_LVL);
   assign empty = (level == '0);
   assign pop   = out_valid && out_ready;
   assign push  = cand && (!full || pop);
   assign drop  = cand && full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= cand_ent;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         lock_cnt <= '0;
      end else begin
         state    <= state_nx;
         lock_cnt <= lock_nx;
      end
   end

   // Lock leaves on the cycle after the counter has read zero.
   always_comb begin
      state_nx = state;
      lock_nx  = lock_cnt;
      unique case (state)
         RUN: begin
            if (pop && (head[2:0] == HARD_DROP)) begin
               state_nx = LOCK;
               lock_nx  = LOCK_LOAD;
            end
         end
         LOCK: begin
            if (lock_cnt == '0) begin
               state_nx = RUN;
            end else begin
               lock_nx = lock_cnt - 1'b1;
            end
         end
      endcase
   end

   assign out_valid  = !empty && (state == RUN);
   assign out_cmd    = out_valid ? head[2:0] : 3'b000;
   assign out_src    = out_valid ? head[3] : 1'b0;
   assign fifo_level = level;

endmodule
